// File: rtl/key_encoder_pkg.sv
// Shared types and helpers for the key encoder front-end.
package key_encoder_pkg;

  localparam int BCD_W = 4;
  localparam int NUM_KEYS = 10;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    FIRE,
    HOLD,
    RELEASE
  } state_t;

  // Classification of one synchronised key sample.
  typedef struct packed {
    logic             none;
    logic             single;
    logic             multi;
    logic [BCD_W-1:0] code;
  } key_class_t;

  // One-hot to index with a single-bit check; code is only meaningful when single is set.
  function automatic key_class_t onehot_to_index(input logic [NUM_KEYS-1:0] v);
    key_class_t r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        n++;
        r.code = BCD_W'(i);
      end
    end
    r.none   = (n == 0);
    r.single = (n == 1);
    r.multi  = (n > 1);
    return r;
  endfunction

endpackage

// File: rtl/key_encoder_sync.sv
// Two-flop synchroniser for asynchronous button inputs, cleared to 0 on reset.
module key_encoder_sync #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Both stages shift every clock; only q is safe to use downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Button front-end: synchronise, debounce and encode one digit key to BCD for the display stage.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no candidate; waiting for exactly one key
// DEBOUNCE | candidate key seen; counting consecutive stable samples
// FIRE     | strobe cycle; ready high, new code on S0..S3
// HOLD     | press accepted; waiting for all keys to be released
// RELEASE  | all keys released; counting stable released samples
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_KEYS        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                S0,
  output logic                S1,
  output logic                S2,
  output logic                S3,
  output logic                ready,
  output logic                key_error
);

  import key_encoder_pkg::*;

  if (NUM_KEYS != 10) begin : g_num_keys_check
    $error("key_encoder: NUM_KEYS must be 10 for BCD encoding");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_debounce_check
    $error("key_encoder: DEBOUNCE_CYCLES must be at least 2");
  end

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] ks;
  logic [NUM_KEYS-1:0] cand_onehot;
  key_class_t          kc;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    cand;
  logic [BCD_W-1:0]    code;

  key_encoder_sync #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (keys),
    .q     (ks)
  );

  assign kc          = onehot_to_index(ks);
  assign cand_onehot = {{(NUM_KEYS-1){1'b0}}, 1'b1} << cand;

  // Press/release sequencing; code and ready are registered on the edge entering FIRE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      code  <= BCD_BLANK;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (kc.single) begin
            state <= DEBOUNCE;
            cand  <= kc.code;
          end
        end
        DEBOUNCE: begin
          if (ks == cand_onehot) begin
            if (cnt == CNT_LAST) begin
              state <= FIRE;
              code  <= cand;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        FIRE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (kc.none) begin
            state <= RELEASE;
            cnt   <= '0;
          end
        end
        RELEASE: begin
          if (kc.none) begin
            if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Multi-key flag follows the synchronised keys regardless of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_error <= 1'b0;
    end else begin
      key_error <= kc.multi;
    end
  end

  assign {S0, S1, S2, S3} = code;

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder with DEBOUNCE_CYCLES = 4.
module tb_key_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keys;
  logic       S0, S1, S2, S3;
  logic       ready;
  logic       key_error;

  int n_tests = 0;
  int n_fail  = 0;

  key_encoder #(
    .DEBOUNCE_CYCLES (D),
    .NUM_KEYS        (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keys      (keys),
    .S0        (S0),
    .S1        (S1),
    .S2        (S2),
    .S3        (S3),
    .ready     (ready),
    .key_error (key_error)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Reference model: the debounce rules written as plain counters and flags.
  logic [9:0] m_s1, m_ks;
  logic [3:0] m_code;
  bit         m_ready, m_err;
  bit         m_latched;     // a press was accepted and keys have not yet been released for good
  bit         m_strobe_cyc;  // the strobe cycle itself: nothing is examined on the edge after a fire
  bit         m_releasing;
  int         m_cand;        // -1 when no candidate key
  int         m_run;
  int         m_pop;
  int         m_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_ks = '0; m_code = 4'hF; m_ready = 0; m_err = 0;
      m_latched = 0; m_strobe_cyc = 0; m_releasing = 0; m_cand = -1; m_run = 0;
    end else begin
      m_pop = $countones(m_ks);
      m_idx = -1;
      for (int i = 0; i < 10; i++) if (m_ks[i]) m_idx = i;
      m_ready = 0;
      m_err = (m_pop > 1);
      if (m_strobe_cyc) begin
        m_strobe_cyc = 0;
      end else if (!m_latched) begin
        if (m_cand < 0) begin
          if (m_pop == 1) begin m_cand = m_idx; m_run = 0; end
        end else if (m_pop == 1 && m_idx == m_cand) begin
          if (m_run == D - 1) begin
            m_code = 4'(m_cand); m_ready = 1; m_latched = 1; m_strobe_cyc = 1;
            m_releasing = 0; m_cand = -1;
          end else m_run++;
        end else begin
          m_cand = -1;
        end
      end else begin
        if (m_pop != 0) m_releasing = 0;
        else if (!m_releasing) begin m_releasing = 1; m_run = 0; end
        else if (m_run == D - 1) begin m_latched = 0; m_releasing = 0; end
        else m_run++;
      end
      m_ks = m_s1;
      m_s1 = keys;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  bit prev_ready = 0;
  int ready_count = 0;
  int last_ready_edge = -1;

  // Drive one key pattern for one clock and compare outputs at the following falling edge.
  task automatic tick(input logic [9:0] k);
    keys = k;
    @(negedge clk);
    check_val("ready", ready, m_ready);
    check_val("code", {S0, S1, S2, S3}, m_code);
    check_val("key_error", key_error, m_err);
    check_val("ready_back_to_back", ready & prev_ready, 0);
    prev_ready = ready;
    if (ready) begin
      ready_count++;
      last_ready_edge = edge_n;
    end
  endtask

  // Assert reset between edges, check outputs before any clock, release on a falling edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check_val("rst_code", {S0, S1, S2, S3}, 4'hF);
    check_val("rst_ready", ready, 0);
    check_val("rst_key_error", key_error, 0);
    @(negedge clk);
    reset = 1'b0;
    prev_ready = 0;
  endtask

  task automatic run_until_ready(input logic [9:0] k, input int budget, output int edge_at);
    edge_at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(k);
      if (ready) begin
        edge_at = edge_n;
        break;
      end
    end
    if (edge_at < 0) check_val("ready_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick('0);
  endtask

  int start, e, cnt0, len, kind;
  logic [9:0] k;

  initial begin
    keys  = '0;
    reset = 1'b1;
    #1;
    check_val("init_code", {S0, S1, S2, S3}, 4'hF);
    check_val("init_ready", ready, 0);
    check_val("init_key_error", key_error, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(3);

    // Clean press of key 7: strobe on the 7th edge counting the first sample as 1.
    cnt0 = ready_count;
    start = edge_n + 1;
    run_until_ready(10'd1 << 7, 20, e);
    check_val("press7_latency", e - start + 1, 7);
    for (int i = 0; i < 13; i++) tick(10'd1 << 7);
    idle_cycles(10);
    check_val("press7_pulses", ready_count - cnt0, 1);
    check_val("press7_code_held", {S0, S1, S2, S3}, 4'b0111);

    // Mid-cycle reset with keys idle: blank code immediately.
    pulse_reset();
    idle_cycles(2);

    // Bounce on key 3: 1,0,1,1,0 then held.
    cnt0 = ready_count;
    tick(10'd1 << 3); tick('0); tick(10'd1 << 3); tick(10'd1 << 3); tick('0);
    start = edge_n + 1;
    run_until_ready(10'd1 << 3, 20, e);
    check_val("bounce_latency", e - start + 1, 7);
    check_val("bounce_pulses", ready_count - cnt0, 1);
    check_val("bounce_code", {S0, S1, S2, S3}, 4'b0011);
    idle_cycles(10);

    // Two keys together: error flag from the third edge, no strobe, code untouched.
    cnt0 = ready_count;
    tick(10'b0000100100);
    tick(10'b0000100100);
    check_val("multi_err_edge2", key_error, 0);
    tick(10'b0000100100);
    check_val("multi_err_edge3", key_error, 1);
    for (int i = 0; i < 7; i++) tick(10'b0000100100);
    idle_cycles(10);
    check_val("multi_pulses", ready_count - cnt0, 0);
    check_val("multi_code", {S0, S1, S2, S3}, 4'b0011);

    // Release bounce after key 9, then a fresh key 0.
    cnt0 = ready_count;
    for (int i = 0; i < 12; i++) tick(10'd1 << 9);
    tick('0); tick(10'd1 << 9); tick('0);
    idle_cycles(6);
    check_val("relbounce_pulses", ready_count - cnt0, 1);
    check_val("relbounce_code", {S0, S1, S2, S3}, 4'b1001);
    run_until_ready(10'd1, 20, e);
    check_val("key0_pulses", ready_count - cnt0, 2);
    check_val("key0_code", {S0, S1, S2, S3}, 4'b0000);
    idle_cycles(10);

    // Reset while debouncing key 5: full debounce restarts after release.
    for (int i = 0; i < 4; i++) tick(10'd1 << 5);
    pulse_reset();
    start = edge_n + 1;
    run_until_ready(10'd1 << 5, 20, e);
    check_val("rst_debounce_latency", e - start + 1, 7);
    check_val("rst_debounce_code", {S0, S1, S2, S3}, 4'b0101);
    idle_cycles(10);

    // Randomised key activity with occasional resets.
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      if (kind < 3) k = '0;
      else if (kind < 8) k = 10'd1 << $urandom_range(0, 9);
      else k = 10'($urandom);
      if ($urandom_range(0, 49) == 0) pulse_reset();
      for (int i = 0; i < len; i++) tick(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
